// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - shared constants and types for the rv32i writeback slice
//
// Holds the datapath/register-file sizing, the instruction-word encodings the
// writeback stage reacts to (EBREAK, bubble, canonical NOP) and the
// writeback state enum.
package rv32i_pkg;

  localparam int XLEN   = 32;
  localparam int NREGS  = 32;
  localparam int REG_AW = $clog2(NREGS);

  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] BUBBLE = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } wb_state_t;

endpackage

// File: rtl/rv32i_wbtop_if.sv
// rtl/rv32i_wbtop_if.sv - bundle of memory-stage, decode-read and status signals of the writeback stage
//
// master: the surrounding pipeline (memory stage retire bundle, decode read
//         addresses) drives the inputs and observes read data, forwarding and
//         status.
// slave : the writeback stage itself.
interface rv32i_wbtop_if;
  import rv32i_pkg::*;

  // retire bundle from the memory stage
  logic [XLEN-1:0]   pc_in;
  logic [31:0]       iw_in;
  logic [XLEN-1:0]   alu_in;
  logic [REG_AW-1:0] wb_reg_in;
  logic              wb_en_in;

  // decode-stage read ports
  logic [REG_AW-1:0] rs1_reg;
  logic [REG_AW-1:0] rs2_reg;
  logic [XLEN-1:0]   rs1_data;
  logic [XLEN-1:0]   rs2_data;

  // forwarding of the write happening this cycle
  logic              df_wb_enable;
  logic [REG_AW-1:0] df_wb_reg;
  logic [XLEN-1:0]   df_wb_data;

  // counters and halt status
  logic [63:0]       cycle_count;
  logic [63:0]       instret_count;
  logic              halted;
  logic [XLEN-1:0]   halt_pc;

  modport master (
    output pc_in, iw_in, alu_in, wb_reg_in, wb_en_in, rs1_reg, rs2_reg,
    input  rs1_data, rs2_data, df_wb_enable, df_wb_reg, df_wb_data,
    input  cycle_count, instret_count, halted, halt_pc
  );

  modport slave (
    input  pc_in, iw_in, alu_in, wb_reg_in, wb_en_in, rs1_reg, rs2_reg,
    output rs1_data, rs2_data, df_wb_enable, df_wb_reg, df_wb_data,
    output cycle_count, instret_count, halted, halt_pc
  );

endinterface

// File: rtl/rv32i_regfile.sv
// rtl/rv32i_regfile.sv - integer register file with one write port and two write-through read ports
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset (clears all entries)
//   we, waddr, wdata   write port; committed at the rising clock edge
//   rs1_reg, rs1_data  read port 1 (combinational)
//   rs2_reg, rs2_data  read port 2 (combinational)
// Entry 0 is hardwired to zero. A read of the address being written in the
// same cycle returns the incoming write data.
module rv32i_regfile
  import rv32i_pkg::*;
#(
  parameter int DATA_W = XLEN,
  parameter int DEPTH  = NREGS,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     rs1_reg,
  input  logic [AW-1:0]     rs2_reg,
  output logic [DATA_W-1:0] rs1_data,
  output logic [DATA_W-1:0] rs2_data
);

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];

  always_comb begin
    regs_d = regs_q;
    if (we && (waddr != '0)) begin
      regs_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // x0 reads as zero regardless of storage; a same-cycle write to the read
  // address is bypassed so decode sees it without waiting for the edge.
  always_comb begin
    rs1_data = '0;
    if (rs1_reg != '0) begin
      if (we && (rs1_reg == waddr)) begin
        rs1_data = wdata;
      end else begin
        rs1_data = regs_q[rs1_reg];
      end
    end
  end

  always_comb begin
    rs2_data = '0;
    if (rs2_reg != '0) begin
      if (we && (rs2_reg == waddr)) begin
        rs2_data = wdata;
      end else begin
        rs2_data = regs_q[rs2_reg];
      end
    end
  end

endmodule

// File: rtl/rv32i_wbtop.sv
// rtl/rv32i_wbtop.sv - RV32I writeback stage: register commit, forwarding, counters and EBREAK halt
//
// Ports:
//   clk    system clock
//   reset  asynchronous active-high reset
//   wb     slave side of rv32i_wbtop_if: retire bundle from the memory stage,
//          decode read ports, forwarding outputs, 64-bit cycle/instret
//          counters, halted flag and halt_pc.
// In RUN every cycle is counted and every non-bubble instruction retires.
// A retiring EBREAK is counted, records its PC and moves the stage to HALTED,
// where writes and counters stop until reset.
module rv32i_wbtop
  import rv32i_pkg::*;
#(
  parameter int XLEN  = rv32i_pkg::XLEN,
  parameter int NREGS = rv32i_pkg::NREGS
) (
  input  logic          clk,
  input  logic          reset,
  rv32i_wbtop_if.slave  wb
);

  wb_state_t       state_q, state_d;
  logic [63:0]     cycle_q, cycle_d;
  logic [63:0]     instret_q, instret_d;
  logic [XLEN-1:0] halt_pc_q, halt_pc_d;

  logic is_ebreak;
  logic is_valid;
  logic we;

  assign is_ebreak = (wb.iw_in == EBREAK);
  assign is_valid  = (wb.iw_in != BUBBLE);

  // The EBREAK itself never writes, even if the memory stage flagged a write.
  assign we = wb.wb_en_in && (wb.wb_reg_in != '0) && (state_q == RUN) && !is_ebreak;

  rv32i_regfile #(
    .DATA_W (XLEN),
    .DEPTH  (NREGS)
  ) u_regfile (
    .clk      (clk),
    .rst      (reset),
    .we       (we),
    .waddr    (wb.wb_reg_in),
    .wdata    (wb.alu_in),
    .rs1_reg  (wb.rs1_reg),
    .rs2_reg  (wb.rs2_reg),
    .rs1_data (wb.rs1_data),
    .rs2_data (wb.rs2_data)
  );

  always_comb begin
    state_d   = state_q;
    cycle_d   = cycle_q;
    instret_d = instret_q;
    halt_pc_d = halt_pc_q;
    case (state_q)
      RUN: begin
        cycle_d = cycle_q + 64'd1;
        if (is_valid) begin
          instret_d = instret_q + 64'd1;
        end
        if (is_ebreak) begin
          halt_pc_d = wb.pc_in;
          state_d   = HALTED;
        end
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= RUN;
      cycle_q   <= '0;
      instret_q <= '0;
      halt_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      cycle_q   <= cycle_d;
      instret_q <= instret_d;
      halt_pc_q <= halt_pc_d;
    end
  end

  assign wb.df_wb_enable  = we;
  assign wb.df_wb_reg     = wb.wb_reg_in;
  assign wb.df_wb_data    = wb.alu_in;
  assign wb.cycle_count   = cycle_q;
  assign wb.instret_count = instret_q;
  assign wb.halted        = (state_q == HALTED);
  assign wb.halt_pc       = halt_pc_q;

endmodule

// File: tb/tb_rv32i_wbtop.sv
// tb/tb_rv32i_wbtop.sv - directed self-checking bench for rv32i_wbtop
module tb_rv32i_wbtop;
  import rv32i_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  rv32i_wbtop_if wb_if ();

  rv32i_wbtop dut (
    .clk   (clk),
    .reset (reset),
    .wb    (wb_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] pat [10];
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    wb_if.pc_in     = '0;
    wb_if.iw_in     = BUBBLE;
    wb_if.alu_in    = '0;
    wb_if.wb_reg_in = '0;
    wb_if.wb_en_in  = 1'b0;
    wb_if.rs1_reg   = 5'd5;
    wb_if.rs2_reg   = 5'd0;
    tick();
    tick();

    // reset state
    check("rst_cycle",   wb_if.cycle_count, 64'd0);
    check("rst_instret", wb_if.instret_count, 64'd0);
    check("rst_halted",  {63'd0, wb_if.halted}, 64'd0);
    check("rst_halt_pc", {32'd0, wb_if.halt_pc}, 64'd0);
    check("rst_x5",      {32'd0, wb_if.rs1_data}, 64'd0);

    // write x5 = DEADBEEF: bypass now, stored after the edge
    reset = 1'b0;
    wb_if.pc_in     = 32'h0000_0000;
    wb_if.iw_in     = NOP;
    wb_if.wb_en_in  = 1'b1;
    wb_if.wb_reg_in = 5'd5;
    wb_if.alu_in    = 32'hDEAD_BEEF;
    #1;
    check("x5_bypass",   {32'd0, wb_if.rs1_data}, 64'hDEAD_BEEF);
    check("x5_df_en",    {63'd0, wb_if.df_wb_enable}, 64'd1);
    check("x5_df_reg",   {59'd0, wb_if.df_wb_reg}, 64'd5);
    check("x5_df_data",  {32'd0, wb_if.df_wb_data}, 64'hDEAD_BEEF);
    tick();
    wb_if.wb_en_in = 1'b0;
    wb_if.iw_in    = BUBBLE;
    #1;
    check("x5_stored",   {32'd0, wb_if.rs1_data}, 64'hDEAD_BEEF);
    check("cnt1_cycle",  wb_if.cycle_count, 64'd1);
    check("cnt1_instret", wb_if.instret_count, 64'd1);

    // write to x0 is dropped
    wb_if.iw_in     = NOP;
    wb_if.wb_en_in  = 1'b1;
    wb_if.wb_reg_in = 5'd0;
    wb_if.alu_in    = 32'h1234_5678;
    wb_if.rs1_reg   = 5'd0;
    #1;
    check("x0_bypass",   {32'd0, wb_if.rs1_data}, 64'd0);
    check("x0_df_en",    {63'd0, wb_if.df_wb_enable}, 64'd0);
    tick();
    check("x0_stored",   {32'd0, wb_if.rs1_data}, 64'd0);

    // both read ports bypass the same destination
    wb_if.wb_reg_in = 5'd9;
    wb_if.alu_in    = 32'hA5A5_A5A5;
    wb_if.rs1_reg   = 5'd9;
    wb_if.rs2_reg   = 5'd9;
    #1;
    check("x9_rs1_bypass", {32'd0, wb_if.rs1_data}, 64'hA5A5_A5A5);
    check("x9_rs2_bypass", {32'd0, wb_if.rs2_data}, 64'hA5A5_A5A5);
    tick();
    wb_if.wb_en_in = 1'b0;
    #1;
    check("x9_rs1_stored", {32'd0, wb_if.rs1_data}, 64'hA5A5_A5A5);
    check("x9_rs2_stored", {32'd0, wb_if.rs2_data}, 64'hA5A5_A5A5);
    check("cnt3_cycle",    wb_if.cycle_count, 64'd3);
    check("cnt3_instret",  wb_if.instret_count, 64'd3);

    // reset pulse, then 10 cycles: 6 instructions, 4 bubbles
    reset = 1'b1;
    tick();
    check("rst2_x9", {32'd0, wb_if.rs1_data}, 64'd0);
    reset = 1'b0;
    pat[0] = NOP;          pat[1] = BUBBLE;       pat[2] = 32'h00A0_0093;
    pat[3] = 32'h0020_8133; pat[4] = BUBBLE;      pat[5] = NOP;
    pat[6] = BUBBLE;       pat[7] = 32'h0000_1137; pat[8] = NOP;
    pat[9] = BUBBLE;
    for (int i = 0; i < 10; i++) begin
      wb_if.iw_in = pat[i];
      tick();
    end
    check("mix_cycle",   wb_if.cycle_count, 64'd10);
    check("mix_instret", wb_if.instret_count, 64'd6);

    // x3 = 0x11, then EBREAK attempting x3 = 7
    wb_if.iw_in     = NOP;
    wb_if.wb_en_in  = 1'b1;
    wb_if.wb_reg_in = 5'd3;
    wb_if.alu_in    = 32'h0000_0011;
    tick();
    wb_if.pc_in  = 32'h0000_0040;
    wb_if.iw_in  = EBREAK;
    wb_if.alu_in = 32'h0000_0007;
    #1;
    check("ebrk_df_en", {63'd0, wb_if.df_wb_enable}, 64'd0);
    check("ebrk_pre_halted", {63'd0, wb_if.halted}, 64'd0);
    tick();
    wb_if.pc_in     = 32'h0000_0044;
    wb_if.iw_in     = NOP;
    wb_if.wb_reg_in = 5'd4;
    wb_if.alu_in    = 32'h0000_0099;
    wb_if.rs1_reg   = 5'd3;
    wb_if.rs2_reg   = 5'd4;
    #1;
    check("halt_halted",  {63'd0, wb_if.halted}, 64'd1);
    check("halt_pc",      {32'd0, wb_if.halt_pc}, 64'h40);
    check("halt_x3",      {32'd0, wb_if.rs1_data}, 64'h11);
    check("halt_x4_byp",  {32'd0, wb_if.rs2_data}, 64'd0);
    check("halt_df_en",   {63'd0, wb_if.df_wb_enable}, 64'd0);
    check("halt_cycle",   wb_if.cycle_count, 64'd12);
    check("halt_instret", wb_if.instret_count, 64'd8);
    tick();
    tick();
    tick();
    check("frz_x4",      {32'd0, wb_if.rs2_data}, 64'd0);
    check("frz_cycle",   wb_if.cycle_count, 64'd12);
    check("frz_instret", wb_if.instret_count, 64'd8);
    check("frz_halted",  {63'd0, wb_if.halted}, 64'd1);

    // asynchronous reset between clock edges
    wb_if.wb_en_in = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("arst_cycle",   wb_if.cycle_count, 64'd0);
    check("arst_instret", wb_if.instret_count, 64'd0);
    check("arst_halted",  {63'd0, wb_if.halted}, 64'd0);
    check("arst_halt_pc", {32'd0, wb_if.halt_pc}, 64'd0);
    check("arst_x3",      {32'd0, wb_if.rs1_data}, 64'd0);
    check("arst_df_en",   {63'd0, wb_if.df_wb_enable}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rv32i_wbtop.md
# rv32i_wbTop

Writeback stage of the five-stage RV32I pipeline, directly downstream of the memory stage. Accepts the registered pc/iw/result/destination bundle from the memory stage and commits results to a 32×32 integer register file. Serves the decode stage's two read ports with write-through bypass and publishes the in-flight write on a forwarding port. Also keeps 64-bit cycle and retired-instruction counters and a halt state machine triggered by EBREAK.

## Interface
Parameters:
- XLEN, 32, datapath width
- NREGS, 32, architectural registers (x0..x31)

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- pc_in  input  32  PC of retiring instruction, from memory stage
- iw_in  input  32  instruction word, from memory stage
- alu_in  input  32  result to write back, from memory stage
- wb_reg_in  input  5  destination register
- wb_en_in  input  1  writeback enable
- rs1_reg  input  5  decode-stage read address 1
- rs2_reg  input  5  decode-stage read address 2
- rs1_data  output  32  read data 1 (combinational)
- rs2_data  output  32  read data 2 (combinational)
- df_wb_enable  output  1  forwarding: write occurring this cycle
- df_wb_reg  output  5  forwarding: destination register
- df_wb_data  output  32  forwarding: data being written
- cycle_count  output  64  cycles spent in RUN
- instret_count  output  64  instructions retired
- halted  output  1  high once EBREAK has retired
- halt_pc  output  32  PC of the EBREAK that halted the core

## Operation
- Effective write: we = wb_en_in & (wb_reg_in != 0) & (state == RUN).
- Register file: on posedge clk, if we, regs[wb_reg_in] <= alu_in. x0 never stored; reads of x0 return 0.
- Read ports: rsN_data = 0 if rsN_reg == 0; else alu_in if we && rsN_reg == wb_reg_in (write-through); else regs[rsN_reg].
- Forwarding: df_wb_enable = we, df_wb_reg = wb_reg_in, df_wb_data = alu_in. All combinational, unregistered.
- Valid retirement: iw_in != 32'h0000_0000. The all-zero word is a pipeline bubble and is never counted.
- State machine, two states:
  - RUN: cycle_count += 1 every cycle. instret_count += 1 on each valid retirement. If iw_in == EBREAK (32'h0010_0073), count it, latch halt_pc <= pc_in, and go to HALTED at the next edge.
  - HALTED: writes suppressed (we = 0), both counters frozen, halted = 1. Read ports keep returning register contents. Only reset exits.
- EBREAK retirement cycle: the EBREAK itself asserts no write, even if wb_en_in = 1. The instruction in the following cycle is ignored.
- Counters wrap modulo 2^64 without a flag.

## Timing
- Reset (async assert) forces:
  - all 32 registers = 0
  - cycle_count = 0, instret_count = 0
  - halt_pc = 0, state = RUN, halted = 0
- Reset deasserts synchronously to clk.
- Write latency: value presented at edge N is visible from regs at N+1. The bypass makes it visible to readers combinationally in cycle N.
- Counters: the cycle after the first RUN edge following reset release reads 1. instret updates one edge after the retiring instruction is presented.
- halted rises one edge after EBREAK is presented on iw_in. halt_pc is valid in that same cycle.
- Reset asserted mid-operation: immediate return to the reset state. Any write in progress that cycle is lost.
- Both read ports addressing wb_reg_in simultaneously: both bypass.

## Structure
- Shared package rv32i_pkg holds:
  - EBREAK and NOP/bubble constants
  - XLEN and NREGS
  - the wb_state_t enum {RUN, HALTED}
- Sub-module rv32i_regFile contains the array, write port, x0 masking and the two bypassed read ports.
- rv32i_wbTop holds the counters, the FSM and the forwarding assignments.

## Test plan
- Reset then write x5 = 32'hDEAD_BEEF (wb_en_in=1): rs1_reg=5 returns DEADBEEF in the same cycle (bypass) and on the following cycle (stored); df_wb_enable=1, df_wb_reg=5.
- Write x0 = 32'h1234_5678 with wb_en_in=1: rs1_data for x0 = 0, df_wb_enable = 0.
- 10 cycles carrying 6 nonzero iw and 4 zero bubbles: instret_count = 6, cycle_count = 10.
- EBREAK at pc 32'h0000_0040 with wb_en_in=1, wb_reg_in=3, alu_in=7:
  - next cycle: halted = 1, halt_pc = 0x40, x3 unchanged
  - later valid writes to x4: ignored
  - counters frozen
- Assert reset asynchronously mid-clock while HALTED with counters nonzero: all outputs zero immediately, halted = 0, before the next clk edge.
- rs1_reg = rs2_reg = 9 while writing x9 = 32'hA5A5_A5A5: both ports return A5A5A5A5.
